// File: rtl/axil_cmd_pkg.sv
// Shared types and constants for the AXI-Lite command master.
package axil_cmd_pkg;

  localparam int unsigned DataWidth = 32;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrRsp,
    StRdReq,
    StRdRsp,
    StRsp
  } state_e;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Saturating response-timeout counter; terminal is high once TimeoutCycles-1 is reached.
module axil_timeout_cnt #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign terminal_o = (cnt_q == CntMax);

endmodule

// File: rtl/axil_cmd_master.sv
// Command/response stream to single-beat AXI-Lite master, one transaction outstanding,
// with a response timeout after the address phase.
module axil_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_M_AXI_DATA_WIDTH = DataWidth,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                            cmd_aclk,
  input  logic                            cmd_arst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned StrbW = C_M_AXI_DATA_WIDTH / 8;

  state_e                          state_q, state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            arvalid_q, arvalid_d;
  logic                            bready_q, bready_d;
  logic                            rready_q, rready_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic                            rsp_timeout_q, rsp_timeout_d;
  logic [1:0]                      rsp_resp_q, rsp_resp_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]                wstrb_q, wstrb_d;

  logic cnt_clear, cnt_en, cnt_tc;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q & M_AXI_WREADY;
  assign ar_hs = arvalid_q & M_AXI_ARREADY;
  assign b_hs  = bready_q & M_AXI_BVALID;
  assign r_hs  = rready_q & M_AXI_RVALID;

  axil_timeout_cnt #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (cmd_aclk),
    .rst_i     (cmd_arst),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_en),
    .terminal_o(cnt_tc)
  );

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Both ready lines stay high so stray late responses are swallowed.
        cmd_ready_d = 1'b1;
        bready_d    = 1'b1;
        rready_d    = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_wr) begin
            state_d   = StWrReq;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            bready_d  = 1'b0;
          end else begin
            state_d   = StRdReq;
            arvalid_d = 1'b1;
            rready_d  = 1'b0;
          end
        end
      end
      StWrReq: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d   = StWrRsp;
          bready_d  = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      StWrRsp, StRdRsp: begin
        // A real response beats a timeout that lands in the same cycle.
        if ((state_q == StWrRsp) ? b_hs : r_hs) begin
          rsp_resp_d    = (state_q == StWrRsp) ? M_AXI_BRESP : M_AXI_RRESP;
          rsp_rdata_d   = (state_q == StWrRsp) ? '0 : M_AXI_RDATA;
          rsp_timeout_d = 1'b0;
        end else if (cnt_tc) begin
          rsp_resp_d    = RespSlvErr;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
        if (((state_q == StWrRsp) ? b_hs : r_hs) || cnt_tc) begin
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          bready_d    = 1'b0;
          rready_d    = 1'b0;
        end
      end
      StRdReq: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = StRdRsp;
          rready_d  = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          state_d       = StIdle;
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          bready_d      = 1'b1;
          rready_d      = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cmd_aclk) begin
    if (cmd_arst) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b1;
      rready_q      <= 1'b1;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_resp_q    <= RespOkay;
      rsp_rdata_q   <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master: directed commands, scripted slave, negedge monitor.
module tb_axil_cmd_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  logic        clk;
  logic        cmd_arst;
  logic        cmd_valid, cmd_wr, rsp_ready;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;

  logic        cmd_ready, rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [11:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  int   n_checks = 0;
  int   n_fail = 0;
  int   aw_beats = 0;
  int   w_beats = 0;
  rsp_t exp_q[$];
  rsp_t e;

  axil_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(12),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .cmd_aclk     (clk),
    .cmd_arst     (cmd_arst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(m_awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (m_wready),
    .M_AXI_BRESP  (m_bresp),
    .M_AXI_BVALID (m_bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(m_arready),
    .M_AXI_RDATA  (m_rdata),
    .M_AXI_RRESP  (m_rresp),
    .M_AXI_RVALID (m_rvalid),
    .M_AXI_RREADY (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait budget expired, required the event to occur", name);
  endtask

  // Monitor: scoreboard pop on response handshake plus AXI valid-stability rules.
  logic prev_aw_pend = 1'b0, prev_w_pend = 1'b0, prev_ar_pend = 1'b0;
  logic prev_aw_hs = 1'b0, prev_w_hs = 1'b0, prev_ar_hs = 1'b0;
  always @(negedge clk) begin
    if (cmd_arst) begin
      prev_aw_pend = 1'b0; prev_w_pend = 1'b0; prev_ar_pend = 1'b0;
      prev_aw_hs = 1'b0; prev_w_hs = 1'b0; prev_ar_hs = 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 resp=%0b, required no response",
                   rsp_resp);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, e.resp});
          chk1("rsp_timeout", rsp_timeout, e.to);
        end
      end
      if (prev_aw_pend) chk1("awvalid_held", awvalid, 1'b1);
      if (prev_w_pend)  chk1("wvalid_held", wvalid, 1'b1);
      if (prev_ar_pend) chk1("arvalid_held", arvalid, 1'b1);
      if (prev_aw_hs)   chk1("awvalid_drop", awvalid, 1'b0);
      if (prev_w_hs)    chk1("wvalid_drop", wvalid, 1'b0);
      if (prev_ar_hs)   chk1("arvalid_drop", arvalid, 1'b0);
      if (awvalid || wvalid) chk1("bready_in_wr_req", bready, 1'b0);
      if (awvalid && m_awready) aw_beats++;
      if (wvalid && m_wready) w_beats++;
      prev_aw_pend = awvalid && !m_awready;
      prev_w_pend  = wvalid && !m_wready;
      prev_ar_pend = arvalid && !m_arready;
      prev_aw_hs   = awvalid && m_awready;
      prev_w_hs    = wvalid && m_wready;
      prev_ar_hs   = arvalid && m_arready;
    end
  end

  task automatic do_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input bit push, input logic [31:0] e_rdata,
                        input logic [1:0] e_resp, input logic e_to);
    int n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (n >= 100) expire("cmd_ready_wait");
    if (push) exp_q.push_back('{rdata: e_rdata, resp: e_resp, to: e_to});
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic slave_wr(input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] bresp, input bit give_b);
    fork
      begin : aw_ch
        int n = 0;
        while (!awvalid && n < 100) begin tick(); n++; end
        if (n >= 100) expire("awvalid_wait");
        repeat (aw_dly) tick();
        m_awready = 1'b1; tick(); m_awready = 1'b0;
      end
      begin : w_ch
        int n = 0;
        while (!wvalid && n < 100) begin tick(); n++; end
        if (n >= 100) expire("wvalid_wait");
        repeat (w_dly) tick();
        m_wready = 1'b1; tick(); m_wready = 1'b0;
      end
    join
    if (give_b) begin
      int n = 0;
      repeat (b_dly) tick();
      m_bvalid = 1'b1; m_bresp = bresp;
      while (!bready && n < 100) begin tick(); n++; end
      if (n >= 100) expire("bready_wait");
      tick();
      m_bvalid = 1'b0; m_bresp = 2'b00;
    end
  endtask

  task automatic slave_rd(input int ar_dly, input int r_dly, input logic [31:0] data,
                          input logic [1:0] rresp);
    int n = 0;
    while (!arvalid && n < 100) begin tick(); n++; end
    if (n >= 100) expire("arvalid_wait");
    repeat (ar_dly) tick();
    m_arready = 1'b1; tick(); m_arready = 1'b0;
    repeat (r_dly) tick();
    m_rvalid = 1'b1; m_rdata = data; m_rresp = rresp;
    n = 0;
    while (!rready && n < 100) begin tick(); n++; end
    if (n >= 100) expire("rready_wait");
    tick();
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    if (n >= 300) expire("response_wait");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int aw0, w0;
    cmd_arst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b1; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    m_bresp = 2'b00; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;

    // Reset values
    repeat (3) tick();
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_bready", bready, 1'b1);
    chk1("rst_rready", rready, 1'b1);
    chk("rst_rsp_resp", {30'b0, rsp_resp}, 32'h0);
    chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_awaddr", {20'b0, awaddr}, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    cmd_arst = 1'b0;
    tick();
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Write to an always-ready slave, cycle-exact
    m_awready = 1'b1; m_wready = 1'b1;
    exp_q.push_back('{rdata: 32'h0, resp: 2'b00, to: 1'b0});
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 12'h104; cmd_wdata = 32'hDEADBEEF;
    cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk1("c1_awvalid", awvalid, 1'b1);
    chk1("c1_wvalid", wvalid, 1'b1);
    chk("c1_awaddr", {20'b0, awaddr}, 32'h104);
    chk("c1_wdata", wdata, 32'hDEADBEEF);
    chk("c1_wstrb", {28'b0, wstrb}, 32'hF);
    chk1("c1_cmd_ready", cmd_ready, 1'b0);
    tick();
    m_awready = 1'b0; m_wready = 1'b0;
    chk1("c2_awvalid", awvalid, 1'b0);
    chk1("c2_bready", bready, 1'b1);
    chk1("c2_rsp_valid", rsp_valid, 1'b0);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    tick();
    m_bvalid = 1'b0;
    chk1("c3_rsp_valid", rsp_valid, 1'b1);
    chk1("c3_bready", bready, 1'b0);
    tick();
    chk1("c4_rsp_valid", rsp_valid, 1'b0);
    chk1("c4_cmd_ready", cmd_ready, 1'b1);

    // Read with a skewed slave
    fork
      do_cmd(1'b0, 12'h1FC, 32'h0, 4'h0, 1'b1, 32'h12345678, 2'b00, 1'b0);
      slave_rd(5, 3, 32'h12345678, 2'b00);
    join
    chk("rd_araddr", {20'b0, araddr}, 32'h1FC);
    wait_idle();

    // Write with W accepted four cycles before AW
    aw0 = aw_beats; w0 = w_beats;
    fork
      do_cmd(1'b1, 12'h020, 32'h0BADF00D, 4'hC, 1'b1, 32'h0, 2'b00, 1'b0);
      slave_wr(4, 0, 1, 2'b00, 1'b1);
    join
    wait_idle();
    chk("skew_aw_beats", 32'(aw_beats - aw0), 32'd1);
    chk("skew_w_beats", 32'(w_beats - w0), 32'd1);

    // Timeout: B never returned; response 16 cycles after entering the wait
    fork
      do_cmd(1'b1, 12'h040, 32'h11112222, 4'hF, 1'b1, 32'h0, 2'b10, 1'b1);
      slave_wr(0, 0, 0, 2'b00, 1'b0);
    join
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("timeout_latency", 32'(n), 32'd16);
    wait_idle();
    // Late B in IDLE must be swallowed silently
    chk1("idle_bready", bready, 1'b1);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    tick();
    m_bvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("late_b_no_rsp", rsp_valid, 1'b0);
      tick();
    end

    // Response backpressure, read with SLVERR from the slave
    rsp_ready = 1'b0;
    fork
      do_cmd(1'b0, 12'h080, 32'h0, 4'h0, 1'b1, 32'hA5A50F0F, 2'b10, 1'b0);
      slave_rd(0, 0, 32'hA5A50F0F, 2'b10);
    join
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    if (n >= 50) expire("bp_rsp_valid");
    for (int i = 0; i < 10; i++) begin
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hA5A50F0F);
      chk("bp_rsp_resp", {30'b0, rsp_resp}, 32'h2);
      chk1("bp_rsp_timeout", rsp_timeout, 1'b0);
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk1("bp_release_rsp_valid", rsp_valid, 1'b0);
    chk1("bp_release_cmd_ready", cmd_ready, 1'b1);

    // Reset while waiting for B abandons the transaction
    fork
      do_cmd(1'b1, 12'h0C0, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, 2'b00, 1'b0);
      slave_wr(0, 0, 0, 2'b00, 1'b0);
    join
    chk1("wr_rsp_bready", bready, 1'b1);
    cmd_arst = 1'b1;
    tick();
    cmd_arst = 1'b0;
    chk1("mid_rst_awvalid", awvalid, 1'b0);
    chk1("mid_rst_wvalid", wvalid, 1'b0);
    chk1("mid_rst_arvalid", arvalid, 1'b0);
    chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("mid_rst_cmd_ready", cmd_ready, 1'b0);
    tick();
    chk1("after_rst_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk1("after_rst_no_rsp", rsp_valid, 1'b0);
      tick();
    end

    // Write with delayed SLVERR response after reset recovery
    fork
      do_cmd(1'b1, 12'h3FC, 32'h0000CAFE, 4'h3, 1'b1, 32'h0, 2'b10, 1'b0);
      slave_wr(1, 2, 2, 2'b10, 1'b1);
    join
    chk("final_wstrb_latched", {28'b0, wstrb}, 32'h3);
    wait_idle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI-Lite master that turns a simple command/response stream into single-beat AXI-Lite register writes and reads.
- Sits on the control side of the packet-processor wrapper and drives its 12-bit-address, 32-bit AXI-Lite slave port. Software (MicroBlaze or a host bridge) programs table entries through it.
- One transaction is outstanding at a time.
- A response timeout protects software from a hung slave.

Parameters:
- C_M_AXI_ADDR_WIDTH, 12, AXI-Lite address width.
- C_M_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- TIMEOUT_CYCLES, 1024, number of cycles to wait for B or R after the address phase completes; must be ≥2.

Ports:
- cmd_aclk  in  1  clock
- cmd_arst  in  1  reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  response generated by timeout
- M_AXI_AWADDR  out  ADDR_W
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  ADDR_W
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Clocking and reset: one clock, cmd_aclk. Reset cmd_arst is synchronous and active-high.
- Reset values: all VALID outputs 0; cmd_ready 0 during reset; BREADY=RREADY=1; data, address, rsp_resp and rsp_timeout all 0. The FSM returns to IDLE.
- Reset mid-transaction abandons the transaction; no response is produced.
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP.
- All outputs are registered.
- IDLE:
  - cmd_ready=1, BREADY=1, RREADY=1 so stray late responses are swallowed.
  - On cmd_valid: latch addr/wdata/wstrb.
  - Go to WR_REQ (AWVALID=WVALID=1 next cycle) or RD_REQ (ARVALID=1 next cycle).
  - cmd_ready drops the cycle after acceptance.
- WR_REQ:
  - AW and W complete independently; flags aw_done and w_done.
  - Each VALID drops the cycle after its handshake and is never withdrawn before its handshake.
  - When both are done: go to WR_RSP, BREADY=1, clear the timeout counter.
- WR_RSP:
  - On BVALID: latch BRESP, rsp_rdata=0, go to RSP.
  - Else increment the counter. When the counter reaches TIMEOUT_CYCLES-1: rsp_resp=2'b10, rsp_timeout=1, go to RSP.
- RD_REQ: on ARREADY, drop ARVALID, go to RD_RSP, clear the counter.
- RD_RSP: same as WR_RSP using RVALID; latch RDATA and RRESP.
- Timeout scope: the address phase has no timeout (AXI forbids VALID withdrawal).
- RSP:
  - rsp_valid=1, BREADY=RREADY=0.
  - Hold rsp_* stable until rsp_ready; then go to IDLE with rsp_valid=0 and rsp_timeout=0.
- Latency with an always-ready slave:
  - cmd accept cycle 0, AW/W valid cycle 1.
  - B at cycle 2 at the earliest, rsp_valid cycle 3.
  - Back-to-back command every 4 cycles minimum.
- Counter width: clog2(TIMEOUT_CYCLES). It saturates and does not wrap.
- Simultaneous BVALID and timeout terminal count: BVALID wins (real response, rsp_timeout=0).

Decomposition:
- Package axil_cmd_pkg:
  - FSM state enum.
  - AXI resp constants: OKAY=2'b00, SLVERR=2'b10.
  - DATA_WIDTH=32.
- Sub-module axil_timeout_cnt: clear, enable, terminal-count output.

Test Plan:
- Write, ready slave: cmd_wr=1, addr=0x104, wdata=0xDEADBEEF, wstrb=0xF → AW/W carry those values on cycle 1; BRESP=00 → rsp_valid cycle 3, rsp_resp=00, rsp_rdata=0, rsp_timeout=0.
- Read with skewed slave: addr=0x1FC, ARREADY after 5 cycles, R 3 cycles later with RDATA=0x12345678, RRESP=00 → ARVALID stable until the handshake; rsp_rdata=0x12345678.
- Write with WREADY 4 cycles before AWREADY → WVALID drops after its handshake and AWVALID holds; exactly one AW beat and one W beat; BREADY asserted only after both complete.
- Timeout, TIMEOUT_CYCLES=16, slave never returns B → rsp_valid with rsp_resp=10, rsp_timeout=1. A late BVALID arriving in IDLE is consumed with no second response.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_* stable and cmd_ready=0 throughout; rsp_ready=1 → IDLE next cycle.
- Reset in WR_RSP: cmd_arst=1 for 1 cycle → next cycle all VALIDs 0, cmd_ready 0; cmd_ready=1 the cycle after deassertion; no rsp_valid.
